// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle for the multi-cycle multiply/divide sequencer.
//   start    - request, sampled only while the sequencer is idle
//   alu_ctrl - 4'b0101 mult, 4'b1011 div; any other code makes start a no-op
//   op_a     - rs operand (multiplicand / dividend), two's complement
//   op_b     - rt operand (multiplier / divisor), two's complement
//   busy     - operation in progress, pipeline stalls
//   done     - one-cycle pulse, hi/lo valid while high
//   hi, lo   - registered result (product halves / remainder, quotient)
//   div_zero - sticky divide-by-zero flag
// master drives the request side, slave is the sequencer.
interface muldiv_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, alu_ctrl, op_a, op_b,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, alu_ctrl, op_a, op_b,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply (radix-2 shift-add) and restoring divide for the
// MIPS HI/LO path. Operands are reduced to magnitudes on acceptance, WIDTH iterations run
// one per cycle, and the sign is applied in a final fix-up cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - muldiv_seq_if.slave (start/alu_ctrl/op_a/op_b in, busy/done/hi/lo/div_zero out)
// Configuration:
//   MULDIV_DIV_EN - when defined the divider and div_zero logic are built; otherwise only
//                   mult is accepted, div is ignored and div_zero is tied low.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_seq_if.slave bus
);
   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [3:0]      AluMult = 4'b0101;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial product, multiplier}; div: low half quotient
   logic [WIDTH-1:0]   mcand_q, mcand_d; // |multiplicand| or |divisor|
   logic               neg_q, neg_d;     // result sign
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
   localparam logic [3:0] AluDiv = 4'b1011;
   logic               is_div_q, is_div_d;
   logic               dsign_q, dsign_d;  // dividend sign, gives remainder sign
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH:0]     rem_sh, trial;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_abs   = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
      b_abs   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      prod    = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
      dsign_d  = dsign_q;
      dz_d     = dz_q;
      rem_d    = rem_q;
      rem_sh   = {rem_q, acc_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, mcand_q};
`endif

      case (state_q)
         StIdle: begin
            if (bus.start && bus.alu_ctrl == AluMult) begin
               acc_d   = {{WIDTH{1'b0}}, b_abs};
               mcand_d = a_abs;
               neg_d   = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StCalc;
`ifdef MULDIV_DIV_EN
               is_div_d = 1'b0;
               dz_d     = 1'b0;
            end else if (bus.start && bus.alu_ctrl == AluDiv) begin
               acc_d    = {{WIDTH{1'b0}}, a_abs};
               mcand_d  = b_abs;
               neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
               dsign_d  = bus.op_a[WIDTH-1];
               is_div_d = 1'b1;
               rem_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               if (bus.op_b == '0) begin
                  // raw dividend parked in the idle upper half, reported as hi
                  acc_d   = {bus.op_a, a_abs};
                  dz_d    = 1'b1;
                  state_d = StFix;
               end else begin
                  dz_d    = 1'b0;
                  state_d = StCalc;
               end
`endif
            end
         end
         StCalc: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StFix;
            end
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               // restore (keep shifted remainder) when the trial subtraction borrows
               acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
               rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            end else
`endif
            begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
         end
         StFix: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
            if (dz_q) begin
               hi_d = acc_q[2*WIDTH-1:WIDTH];
               lo_d = '1;
            end else if (is_div_q) begin
               lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = dsign_q ? -rem_q : rem_q;
            end else
`endif
            begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULDIV_DIV_EN
         is_div_q <= 1'b0;
         dsign_q  <= 1'b0;
         dz_q     <= 1'b0;
         rem_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
         is_div_q <= is_div_d;
         dsign_q  <= dsign_d;
         dz_q     <= dz_d;
         rem_q    <= rem_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
   assign bus.div_zero = dz_q;
`else
   assign bus.div_zero = 1'b0;
`endif
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the MIPS multiply/divide path. When the decoded ALU control selects mult (4'b0101) or div (4'b1011), this block replaces the single-cycle ALU result with an iterative radix-2 signed multiply or restoring divide. The result goes into HI/LO registers. `busy` stalls the pipeline until the operation completes. It sits beside the main ALU in EX and is started by the same ALU control code the ALU decoder produces.

## Interface
- WIDTH, 32: operand width; HI/LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- alu_ctrl  in  4  operation: 4'b0101 = mult, 4'b1011 = div; any other value makes `start` a no-op.
- op_a  in  WIDTH  rs operand (multiplicand / dividend), two's complement; sampled on the accepting edge.
- op_b  in  WIDTH  rt operand (multiplier / divisor), two's complement; sampled on the accepting edge.
- busy  out  1  operation in progress; pipeline must stall.
- done  out  1  single-cycle pulse; HI/LO are valid while it is high.
- hi  out  WIDTH  upper product / remainder (registered).
- lo  out  WIDTH  lower product / quotient (registered).
- div_zero  out  1  sticky flag, set by a div with op_b==0, cleared by the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - start && valid alu_ctrl: latch |op_a| and |op_b|, result sign, dividend sign and op.
  - Clear the iteration counter, set busy, go to CALC.
  - Exception: div with op_b==0 goes straight to FIX with div_zero=1.
- **CALC**
  - One iteration per cycle, WIDTH cycles total; counter runs 0..WIDTH-1.
  - mult: shift-add on a 2*WIDTH unsigned accumulator.
  - div: restoring shift-subtract; WIDTH+1-bit partial remainder, WIDTH-bit quotient.
  - When counter==WIDTH-1, go to FIX.
- **FIX**
  - Apply the sign and write hi/lo. Pulse done, drop busy, return to IDLE.
  - mult result: {hi,lo} = signed 2*WIDTH-bit product.
  - div result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: hi = op_a, lo = {WIDTH{1'b1}}, no iterations.
- Magnitudes are WIDTH-bit unsigned, so |−2^(WIDTH−1)| is representable.
  - (−2^31)/(−1) yields lo=0x80000000, hi=0. This is not flagged.
- Invalid alu_ctrl with start: no state change, hi/lo hold, busy stays 0.
- start while busy: ignored. op_a/op_b changes during CALC have no effect.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
- Accepting edge E: busy=1 from E.
- Normal op: done=1 and hi/lo updated at edge E+WIDTH+1, with busy=0 at the same edge. Latency is 33 cycles for WIDTH=32.
- Divide by zero: done at E+1.
- done lasts exactly one cycle. hi/lo hold until the next completion.
- A start in the same cycle done is high is accepted, because the block is IDLE.
- rst_n asserted mid-operation aborts immediately to reset values. No done is produced for the aborted operation.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath and div_zero logic are compiled in, as described above.
- Not defined:
  - Only mult is supported.
  - div is treated as an invalid alu_ctrl: ignored, busy stays 0.
  - div_zero is tied to 0.

## Test plan
- **Signed mult:** op_a=7, op_b=−3 (0xFFFFFFFD), mult, WIDTH=32 -> busy for 33 cycles; done at E+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **Signed div:** op_a=−7, op_b=2, div -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- **Divide by zero:** op_a=0x12345678, op_b=0, div -> done at E+1, hi=0x12345678, lo=0xFFFFFFFF, div_zero=1.
- **Corner cases:**
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- **Start handling:**
  - start pulses during busy with new operands -> ignored; the original result is reported.
  - start on the done cycle -> accepted; second result follows 33 cycles later.
- **Reset mid-op:**
  - rst_n low at cycle 10 of CALC -> busy/done/hi/lo=0 immediately; no done pulse after release.
  - A fresh mult completes normally after reset is released.
